// File: rtl/scarv_soc_bram_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : scarv_soc_bram_arbiter
// Purpose  : Two-requester round-robin arbiter in front of a single-port BRAM,
//            with an address window check and an RLAT-deep response tag pipe.
// Revision : 1.0
//------------------------------------------------------------------------------
module scarv_soc_bram_arbiter #(
  parameter int          DEPTH = 1024,
  parameter logic [31:0] BASE  = 32'h0,
  parameter int          RLAT  = 2,
  localparam int         LW    = $clog2(DEPTH)
) (
  input  logic          g_clk,
  input  logic          g_resetn,

  input  logic          m0_req,
  output logic          m0_gnt,
  input  logic [3:0]    m0_wen,
  input  logic [31:0]   m0_addr,
  input  logic [31:0]   m0_wdata,
  output logic          m0_rsp,
  output logic          m0_err,
  output logic [31:0]   m0_rdata,

  input  logic          m1_req,
  output logic          m1_gnt,
  input  logic [3:0]    m1_wen,
  input  logic [31:0]   m1_addr,
  input  logic [31:0]   m1_wdata,
  output logic          m1_rsp,
  output logic          m1_err,
  output logic [31:0]   m1_rdata,

  output logic          bram_en,
  output logic [3:0]    bram_wen,
  output logic [LW-1:0] bram_addr,
  output logic [31:0]   bram_wdata,
  input  logic [31:0]   bram_rdata
);

  localparam logic [31:0] C_DEPTH = 32'(DEPTH);

  logic            r_prio;
  logic [RLAT-1:0] r_vld;
  logic [RLAT-1:0] r_id;
  logic [RLAT-1:0] r_err;

  logic [31:0]     w_off0;
  logic [31:0]     w_off1;
  logic            w_in0;
  logic            w_in1;
  logic            w_gnt0;
  logic            w_gnt1;
  logic            w_acc;
  logic            w_inr;
  logic            w_rvld;
  logic            w_rid;
  logic            w_rerr;

  // Unsigned subtraction makes addresses below BASE wrap to huge offsets.
  assign w_off0 = m0_addr - BASE;
  assign w_off1 = m1_addr - BASE;
  assign w_in0  = w_off0 < C_DEPTH;
  assign w_in1  = w_off1 < C_DEPTH;

  assign w_gnt0 = g_resetn && m0_req && (!m1_req || !r_prio);
  assign w_gnt1 = g_resetn && m1_req && !w_gnt0;
  assign m0_gnt = w_gnt0;
  assign m1_gnt = w_gnt1;

  assign w_acc      = w_gnt0 || w_gnt1;
  assign w_inr      = w_gnt1 ? w_in1 : w_in0;
  assign bram_en    = w_acc && w_inr;
  assign bram_wen   = bram_en ? (w_gnt1 ? m1_wen : m0_wen) : 4'b0000;
  assign bram_addr  = w_gnt1 ? w_off1[LW-1:0] : w_off0[LW-1:0];
  assign bram_wdata = w_gnt1 ? m1_wdata : m0_wdata;

  // Priority flips only on contested cycles; the holder was just granted.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_prio <= 1'b0;
    end else if (m0_req && m1_req) begin
      r_prio <= ~r_prio;
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_vld <= '0;
      r_id  <= '0;
      r_err <= '0;
    end else begin
      r_vld[0] <= w_acc;
      r_id[0]  <= w_gnt1;
      r_err[0] <= !w_inr;
      for (int i = 1; i < RLAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_id[i]  <= r_id[i-1];
        r_err[i] <= r_err[i-1];
      end
    end
  end

  assign w_rvld = r_vld[RLAT-1];
  assign w_rid  = r_id[RLAT-1];
  assign w_rerr = r_err[RLAT-1];

  assign m0_rsp   = w_rvld && !w_rid;
  assign m1_rsp   = w_rvld && w_rid;
  assign m0_err   = m0_rsp && w_rerr;
  assign m1_err   = m1_rsp && w_rerr;
  assign m0_rdata = (m0_rsp && !w_rerr) ? bram_rdata : 32'h0;
  assign m1_rdata = (m1_rsp && !w_rerr) ? bram_rdata : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_scarv_soc_bram_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_scarv_soc_bram_arbiter
// Purpose  : Scoreboard bench driving RLAT=1 and RLAT=2 arbiters in lockstep.
// Revision : 1.0
//------------------------------------------------------------------------------
module tb_scarv_soc_bram_arbiter;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          LW    = $clog2(DEPTH);

  logic g_clk = 1'b0;
  logic g_resetn = 1'b0;
  always #5 g_clk = ~g_clk;

  logic        m0_req = 1'b0, m1_req = 1'b0;
  logic [3:0]  m0_wen = '0, m1_wen = '0;
  logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;

  logic          gnt0 [2], gnt1 [2], rsp0 [2], rsp1 [2], err0 [2], err1 [2], ben [2];
  logic [3:0]    bwen [2];
  logic [LW-1:0] baddr [2];
  logic [31:0]   bwdata [2], brdata [2], rdata0 [2], rdata1 [2];

  scarv_soc_bram_arbiter #(.DEPTH(DEPTH), .BASE(BASE), .RLAT(1)) dut_l1 (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .m0_req(m0_req), .m0_gnt(gnt0[0]), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rsp(rsp0[0]), .m0_err(err0[0]), .m0_rdata(rdata0[0]),
    .m1_req(m1_req), .m1_gnt(gnt1[0]), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rsp(rsp1[0]), .m1_err(err1[0]), .m1_rdata(rdata1[0]),
    .bram_en(ben[0]), .bram_wen(bwen[0]), .bram_addr(baddr[0]), .bram_wdata(bwdata[0]),
    .bram_rdata(brdata[0])
  );

  scarv_soc_bram_arbiter #(.DEPTH(DEPTH), .BASE(BASE), .RLAT(2)) dut_l2 (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .m0_req(m0_req), .m0_gnt(gnt0[1]), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rsp(rsp0[1]), .m0_err(err0[1]), .m0_rdata(rdata0[1]),
    .m1_req(m1_req), .m1_gnt(gnt1[1]), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rsp(rsp1[1]), .m1_err(err1[1]), .m1_rdata(rdata1[1]),
    .bram_en(ben[1]), .bram_wen(bwen[1]), .bram_addr(baddr[1]), .bram_wdata(bwdata[1]),
    .bram_rdata(brdata[1])
  );

  // Behavioural BRAMs: read-first, latency k+1.
  for (genvar k = 0; k < 2; k++) begin : g_bram
    logic [31:0] mem [DEPTH/4];
    logic [31:0] p1, p2;
    initial for (int i = 0; i < DEPTH/4; i++) mem[i] = 32'hA500_0000 | 32'(i);
    always @(posedge g_clk) begin
      if (ben[k]) begin
        p1 <= mem[baddr[k][LW-1:2]];
        for (int b = 0; b < 4; b++)
          if (bwen[k][b]) mem[baddr[k][LW-1:2]][8*b +: 8] <= bwdata[k][8*b +: 8];
      end
      p2 <= p1;
    end
    assign brdata[k] = (k == 0) ? p1 : p2;
  end

  typedef struct {
    int          due;
    bit          id;
    bit          err;
    bit          chk;
    logic [31:0] data;
  } exp_t;

  exp_t        q1 [$];
  exp_t        q2 [$];
  logic [31:0] shadow [DEPTH/4];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  bit          m_prio = 1'b0;
  bit          in_rst = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rsp(input int k);
    exp_t h;
    bit   have;
    bit   x0, x1;
    h    = '{0, 1'b0, 1'b0, 1'b0, 32'h0};
    have = 1'b0;
    if (k == 0 && q1.size() > 0 && q1[0].due == cyc) begin h = q1.pop_front(); have = 1'b1; end
    if (k == 1 && q2.size() > 0 && q2[0].due == cyc) begin h = q2.pop_front(); have = 1'b1; end
    x0 = have && !h.id;
    x1 = have && h.id;
    chk($sformatf("m0_rsp L%0d c%0d", k+1, cyc), 32'(rsp0[k]), 32'(x0));
    chk($sformatf("m1_rsp L%0d c%0d", k+1, cyc), 32'(rsp1[k]), 32'(x1));
    chk($sformatf("m0_err L%0d c%0d", k+1, cyc), 32'(err0[k]), 32'(x0 && h.err));
    chk($sformatf("m1_err L%0d c%0d", k+1, cyc), 32'(err1[k]), 32'(x1 && h.err));
    if (!x0 || h.err) chk($sformatf("m0_rdata0 L%0d c%0d", k+1, cyc), rdata0[k], 32'h0);
    else if (h.chk)   chk($sformatf("m0_rdata L%0d c%0d", k+1, cyc), rdata0[k], h.data);
    if (!x1 || h.err) chk($sformatf("m1_rdata0 L%0d c%0d", k+1, cyc), rdata1[k], 32'h0);
    else if (h.chk)   chk($sformatf("m1_rdata L%0d c%0d", k+1, cyc), rdata1[k], h.data);
  endtask

  // One clock cycle: drive, check combinational grant/BRAM side, push expectation.
  task automatic cycle(input logic r0, input logic [3:0] w0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic r1, input logic [3:0] w1, input logic [31:0] a1, input logic [31:0] d1);
    bit          e0, e1, inr;
    logic [3:0]  w;
    logic [31:0] a, d, off;
    exp_t        e;
    m0_req = r0; m0_wen = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_wen = w1; m1_addr = a1; m1_wdata = d1;
    @(negedge g_clk); #1;
    for (int k = 0; k < 2; k++) check_rsp(k);
    e0 = !in_rst && r0 && (!r1 || !m_prio);
    e1 = !in_rst && r1 && !e0;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("m0_gnt L%0d c%0d", k+1, cyc), 32'(gnt0[k]), 32'(e0));
      chk($sformatf("m1_gnt L%0d c%0d", k+1, cyc), 32'(gnt1[k]), 32'(e1));
    end
    if (e0 || e1) begin
      a   = e1 ? a1 : a0;
      w   = e1 ? w1 : w0;
      d   = e1 ? d1 : d0;
      off = a - BASE;
      inr = off < 32'(DEPTH);
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("bram_en L%0d c%0d", k+1, cyc), 32'(ben[k]), 32'(inr));
        chk($sformatf("bram_wen L%0d c%0d", k+1, cyc), 32'(bwen[k]), inr ? 32'(w) : 32'h0);
        if (inr) begin
          chk($sformatf("bram_addr L%0d c%0d", k+1, cyc), 32'(baddr[k]), 32'(off[LW-1:0]));
          chk($sformatf("bram_wdata L%0d c%0d", k+1, cyc), bwdata[k], d);
        end
      end
      e.id   = e1;
      e.err  = !inr;
      e.chk  = !inr || (w == 4'b0000);
      e.data = inr ? shadow[off[LW-1:2]] : 32'h0;
      e.due  = cyc + 1; q1.push_back(e);
      e.due  = cyc + 2; q2.push_back(e);
      if (inr)
        for (int b = 0; b < 4; b++)
          if (w[b]) shadow[off[LW-1:2]][8*b +: 8] = d[8*b +: 8];
    end else begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("idle bram_en L%0d c%0d", k+1, cyc), 32'(ben[k]), 32'h0);
        chk($sformatf("idle bram_wen L%0d c%0d", k+1, cyc), 32'(bwen[k]), 32'h0);
      end
    end
    if (!in_rst && r0 && r1) m_prio = !m_prio;
    @(posedge g_clk); #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic both_rd(input logic [31:0] a0, input logic [31:0] a1);
    cycle(1'b1, 4'h0, a0, 32'h0, 1'b1, 4'h0, a1, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH/4; i++) shadow[i] = 32'hA500_0000 | 32'(i);
    @(posedge g_clk); #1;

    // Held in reset with both requesting: everything must stay quiet.
    both_rd(BASE, BASE + 32'h4);
    both_rd(BASE, BASE + 32'h4);
    g_resetn = 1'b1; in_rst = 1'b0;

    // Lone m0 read, granted on the first edge after release.
    cycle(1'b1, 4'h0, BASE + 32'h10, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    idle(3);

    // Continuous contention: grants alternate starting with m0.
    for (int i = 0; i < 6; i++) both_rd(BASE + 32'h20 + 32'(8*i), BASE + 32'h40 + 32'(8*i));
    idle(3);

    // Out-of-range write above the window, then below BASE (wrap).
    cycle(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'b0011, BASE + 32'(DEPTH), 32'h1234_5678);
    idle(1);
    cycle(1'b1, 4'h0, BASE - 32'h4, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    idle(3);

    // Write then read-back across requesters, plus a partial-strobe write.
    cycle(1'b1, 4'hF, BASE + 32'h4, 32'hDEAD_BEEF, 1'b0, 4'h0, 32'h0, 32'h0);
    cycle(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, BASE + 32'h4, 32'h0);
    cycle(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'b0011, BASE + 32'h8, 32'h1111_2222);
    cycle(1'b1, 4'h0, BASE + 32'h8, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    cycle(1'b1, 4'h0, BASE + 32'h3FC, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    idle(3);

    // Uncontested m1 grant keeps priority; contested pairs still alternate.
    cycle(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, BASE + 32'h60, 32'h0);
    both_rd(BASE + 32'h64, BASE + 32'h68);
    both_rd(BASE + 32'h6C, BASE + 32'h70);
    both_rd(BASE + 32'h74, BASE + 32'h78);
    idle(3);

    // Two grants in flight, then asynchronous reset drops their responses.
    both_rd(BASE + 32'h80, BASE + 32'h84);
    both_rd(BASE + 32'h88, BASE + 32'h8C);
    g_resetn = 1'b0; in_rst = 1'b1; m_prio = 1'b0;
    q1.delete(); q2.delete();
    both_rd(BASE + 32'h80, BASE + 32'h84);
    idle(1);
    g_resetn = 1'b1; in_rst = 1'b0;
    both_rd(BASE + 32'h90, BASE + 32'h94);
    idle(3);

    chk("q1 drained", 32'(q1.size()), 32'h0);
    chk("q2 drained", 32'(q2.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/scarv_soc_bram_arbiter.md
SCARV_SOC_BRAM_ARBITER -- requirements
Module: scarv_soc_bram_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning BRAM depth in bytes; LW = $clog2(DEPTH).
REQ-002 SHALL have parameter BASE, default 32'h0, meaning byte base address of the BRAM window.
REQ-003 SHALL have parameter RLAT, default 2, meaning BRAM read latency in cycles; legal values are 1 and 2.
REQ-004 SHALL have port g_clk  in  1  system clock, with all state on its rising edge.
REQ-005 SHALL have port g_resetn  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have, for each requester n in {0,1}, the following ports: mn_req in 1; mn_gnt out 1; mn_wen in 4 (byte write strobes, 0 means read); mn_addr in 32 (byte address); mn_wdata in 32; mn_rsp out 1; mn_err out 1; mn_rdata out 32.
REQ-007 SHALL have port bram_en  out  1  BRAM port enable.
REQ-008 SHALL have port bram_wen  out  4  BRAM byte write enables.
REQ-009 SHALL have port bram_addr  out  LW  BRAM address.
REQ-010 SHALL have port bram_wdata  out  32  BRAM write data.
REQ-011 SHALL have port bram_rdata  in  32  BRAM read data, valid RLAT cycles after bram_en.

Function
REQ-012 A transaction SHALL be accepted on a cycle where mn_req && mn_gnt; mn_gnt SHALL be combinational from the req inputs and the priority state.
REQ-013 At most one mn_gnt SHALL be high per cycle; a lone requester SHALL be granted in the same cycle.
REQ-014 When both request, the requester holding priority SHALL be granted; after any contested grant, priority SHALL pass to the other requester (round-robin); an uncontested grant SHALL leave priority unchanged.
REQ-015 In range SHALL mean (mn_addr - BASE) < DEPTH as unsigned 32-bit arithmetic, with wrap-around below BASE counting as out of range.
REQ-016 For an accepted in-range transaction, the block SHALL in the same cycle drive bram_en=1, bram_wen=mn_wen, bram_addr=(mn_addr-BASE)[LW-1:0] and bram_wdata=mn_wdata.
REQ-017 For an accepted out-of-range transaction, bram_en SHALL stay 0 and no BRAM write SHALL occur.
REQ-018 When no transaction is accepted, bram_en=0 and bram_wen=0; bram_addr and bram_wdata are don't-care.
REQ-019 Each accepted transaction SHALL produce exactly one single-cycle mn_rsp pulse to its issuer, exactly RLAT cycles after acceptance, for both reads and writes.
REQ-020 Response routing SHALL use an RLAT-deep tag pipeline {valid, id, err} that advances every cycle, giving throughput of one transaction per cycle with back-to-back grants allowed.
REQ-021 When mn_rsp=1 with err=0, mn_rdata SHALL equal bram_rdata and mn_err=0.
REQ-022 When mn_rsp=1 with err=1, mn_err=1 and mn_rdata=0.
REQ-023 When mn_rsp=0, mn_rdata=0 and mn_err=0.
REQ-024 Write-response rdata SHALL be whatever bram_rdata holds; requesters ignore it.
REQ-025 Requesters SHALL be responses-always-accepted, with no response back-pressure.
REQ-026 The block SHALL NOT reorder responses; response order SHALL equal grant order.

Reset
REQ-027 On g_resetn=0, all tag pipeline stages SHALL clear asynchronously and priority SHALL be set to requester 0.
REQ-028 While g_resetn=0, all mn_gnt, mn_rsp, mn_err, mn_rdata, bram_en and bram_wen outputs SHALL be 0.
REQ-029 Transactions in flight when reset asserts SHALL produce no response.
REQ-030 The first edge after reset release SHALL be able to accept a transaction.

Verification
REQ-031 Reset, then m0 read addr=BASE+0x10 alone -> m0_gnt same cycle, bram_addr=0x10, m0_rsp exactly RLAT cycles later with m0_rdata=bram_rdata.
REQ-032 m0 and m1 request continuously for 6 cycles after reset -> grants alternate m0,m1,m0,m1,m0,m1, bram_en=1 every cycle, rsp pulses alternate in the same order offset by RLAT.
REQ-033 m1 write wen=4'b0011 to addr=BASE+DEPTH -> bram_en=0, m1_rsp with m1_err=1 and m1_rdata=0 after RLAT; an access at BASE-4 also errors.
REQ-034 m0 write 0xDEADBEEF at BASE+4, next cycle m1 read BASE+4 -> m1_rdata=0xDEADBEEF, one rsp each, no reordering.
REQ-035 Assert g_resetn=0 one cycle after two grants -> no mn_rsp ever appears for those grants; priority returns to m0, so a simultaneous request after release is granted to m0.
REQ-036 Run with RLAT=1 and RLAT=2 -> rsp lag equals RLAT in every scenario above.
